sbox_apb_loader: RTL and testbench
==================================

SBOX_APB_LOADER -- requirements
Module: sbox_apb_loader

Interface
REQ-001 Parameter: TIMEOUT, default 16, the number of consecutive ACCESS cycles with PREADY=0 before the transfer is aborted.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to load the whole S-box table.
- abort  in  1  request to stop the load early.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at the end of a load.
- err  out  1  sticky error flag; cleared when the next start is accepted.
- err_count  out  7  number of failed writes in the current load.
- tbl_addr  out  6  table index; registered.
- tbl_data  in  32  table word; a combinational function of tbl_addr, valid in the same cycle.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write strobe.
- PADDR  out  12  APB address.
- PWDATA  out  32  APB write data.
- PREADY  in  1  APB ready from the slave.
- PSLVERR  in  1  APB slave error.

Function
REQ-004 The block SHALL act as the APB initiator that writes all 64 S-box half-row words (8 boxes x 4 rows x 2 halves) into the DES configuration slave.
REQ-005 Index i SHALL run 0..63 in order; address mapping: PADDR = {1'b0, i[5:3], 2'b00, i[2:1], 3'b000, i[0]}.
- i=0 -> 12'h000; i=1 -> 12'h001; i=3 -> 12'h011; i=63 -> 12'h731.
REQ-006 FSM states SHALL be IDLE, FETCH, SETUP, ACCESS, DONE.
REQ-007 IDLE:
- start=1 -> FETCH; i=0; err=0; err_count=0; tbl_addr<=0.
- start while not IDLE SHALL be ignored.
REQ-008 FETCH (1 cycle): tbl_addr=i; on exit PWDATA<=tbl_data, PADDR<=map(i), PWRITE<=1, PSEL<=1, PENABLE<=0 -> SETUP.
REQ-009 SETUP (1 cycle): PSEL=1, PENABLE=0 -> ACCESS with PENABLE<=1.
REQ-010 ACCESS: PSEL=PENABLE=1; PADDR, PWDATA and PWRITE SHALL stay stable until the transfer completes.
REQ-011 Transfer completes when PREADY=1 in ACCESS:
- PSLVERR=1 -> err<=1, err_count+1.
- PSEL<=0, PENABLE<=0, PWRITE<=0.
- if i==63 or abort latched -> DONE; else i+1, tbl_addr<=i+1 -> FETCH.
REQ-012 Wait counter: counts consecutive ACCESS cycles with PREADY=0. On reaching TIMEOUT:
- the transfer ends exactly as for a completed transfer with PSLVERR=1 (err set, err_count+1, advance or DONE);
- the counter clears on every new ACCESS.
REQ-013 abort SHALL be latched in any non-IDLE state.
- It never truncates SETUP or ACCESS; the current transfer completes.
- In FETCH it goes to DONE with no APB transfer for that index.
- An abort-terminated load SHALL set err=1 without incrementing err_count.
REQ-014 DONE (1 cycle): done=1, busy=0 -> IDLE; the abort latch clears.
REQ-015 busy SHALL be 1 in FETCH, SETUP and ACCESS, and 0 in IDLE and DONE.
REQ-016 PSEL SHALL never be 1 in IDLE, FETCH or DONE; PENABLE=1 only in ACCESS.
REQ-017 With PREADY tied high, each word SHALL take 3 cycles; start sampled at edge 0 -> done pulse in cycle 193.
REQ-018 err_count SHALL NOT wrap; its maximum value is 64.

Reset
REQ-019 rst=0 SHALL force the following immediately, including mid-transfer, with no completion of the APB transfer:
- state=IDLE;
- PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0;
- tbl_addr=0, busy=0, done=0, err=0, err_count=0;
- wait counter and abort latch cleared.

Verification
REQ-020 PREADY=1, PSLVERR=0, tbl_data=ROM of the 64 known S-box words; start -> 64 writes, first PADDR 12'h000 with PWDATA=ROM[0], last PADDR 12'h731 with PWDATA=ROM[63]; done in cycle 193; err=0.
REQ-021 PREADY low for 3 cycles in every ACCESS -> 6 cycles per word, address/data held stable throughout, done in cycle 385.
REQ-022 PSLVERR=1 on i=5 and i=40 only -> err=1, err_count=2, all 64 writes issued.
REQ-023 PREADY stuck 0 at i=10 -> ACCESS lasts exactly 16 cycles, then err_count=1 and i=11 proceeds.
REQ-024 abort asserted during ACCESS of i=7 with PREADY low 2 cycles -> i=7 completes, no i=8 transfer, done pulses, err=1, err_count=0.
REQ-025 rst pulsed low during SETUP of i=20 -> PSEL=0 at once, all outputs at reset values; a following start restarts at PADDR 12'h000.

Source files
------------

// File: rtl/sbox_apb_loader.sv
// APB initiator that streams the 64 S-box half-row words
// from a combinational table into the DES configuration slave.
module sbox_apb_loader #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [6:0]  err_count,
   output logic [5:0]  tbl_addr,
   input  logic [31:0] tbl_data,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [11:0] PADDR,
   output logic [31:0] PWDATA,
   input  logic        PREADY,
   input  logic        PSLVERR
);

   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SETUP,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [5:0]    r_idx;
   logic [5:0]    r_tbl_addr;
   logic [WW-1:0] r_wait;
   logic          r_abort;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic [6:0]    r_cnt;
   logic          r_psel;
   logic          r_penable;
   logic          r_pwrite;
   logic [11:0]   r_paddr;
   logic [31:0]   r_pwdata;

   logic          w_abort;
   logic          w_last;
   logic          w_tmo;
   logic          w_end;
   logic          w_fail;
   logic [11:0]   w_map;
   logic [6:0]    w_cnt_inc;

   assign w_map = {1'b0, r_idx[5:3], 2'b00,
                   r_idx[2:1], 3'b000, r_idx[0]};
   assign w_abort   = r_abort | abort;
   assign w_last    = (r_idx == 6'd63);
   assign w_tmo     = (r_wait == WW'(TIMEOUT - 1));
   assign w_end     = PREADY | w_tmo;
   // a timeout counts as a failed write
   assign w_fail    = ~PREADY | PSLVERR;
   assign w_cnt_inc = (r_cnt == 7'd64) ? r_cnt
                                       : r_cnt + 7'd1;

   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign err_count = r_cnt;
   assign tbl_addr  = r_tbl_addr;
   assign PSEL      = r_psel;
   assign PENABLE   = r_penable;
   assign PWRITE    = r_pwrite;
   assign PADDR     = r_paddr;
   assign PWDATA    = r_pwdata;

   // load sequencer with registered APB and status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_tbl_addr <= '0;
         r_wait     <= '0;
         r_abort    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_FETCH;
                  r_idx      <= '0;
                  r_tbl_addr <= '0;
                  r_err      <= 1'b0;
                  r_cnt      <= '0;
                  r_abort    <= 1'b0;
                  r_busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               r_abort <= w_abort;
               if (w_abort) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
               end else begin
                  r_state   <= S_SETUP;
                  r_pwdata  <= tbl_data;
                  r_paddr   <= w_map;
                  r_pwrite  <= 1'b1;
                  r_psel    <= 1'b1;
                  r_penable <= 1'b0;
               end
            end
            S_SETUP: begin
               r_abort   <= w_abort;
               r_state   <= S_ACCESS;
               r_penable <= 1'b1;
               r_wait    <= '0;
            end
            S_ACCESS: begin
               r_abort <= w_abort;
               if (w_end) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_pwrite  <= 1'b0;
                  if (w_fail) begin
                     r_err <= 1'b1;
                     r_cnt <= w_cnt_inc;
                  end
                  if (w_last || w_abort) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     if (w_abort)
                        r_err <= 1'b1;
                  end else begin
                     r_state    <= S_FETCH;
                     r_idx      <= r_idx + 6'd1;
                     r_tbl_addr <= r_idx + 6'd1;
                  end
               end else begin
                  r_wait <= r_wait + WW'(1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_abort <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_apb_loader.sv
// Directed bench for sbox_apb_loader with a small
// APB slave model and a transfer log.
module tb_sbox_apb_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        PREADY = 1'b0;
   logic        PSLVERR = 1'b0;
   logic [31:0] tbl_data;
   logic        busy, done, err;
   logic [6:0]  err_count;
   logic [5:0]  tbl_addr;
   logic        PSEL, PENABLE, PWRITE;
   logic [11:0] PADDR;
   logic [31:0] PWDATA;

   int checks = 0;
   int errors = 0;

   int wait_n = 0;
   int stuck_idx = -1;
   int e0 = -1;
   int e1 = -1;

   int          k = 0;
   int          n_xfer = 0;
   int          unstable = 0;
   int          viol = 0;
   logic [11:0] cap_a;
   logic [31:0] cap_d;
   logic [11:0] log_a [512];
   logic [31:0] log_d [512];
   int          log_l [512];

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [5:0] a);
      rom = {a, 2'b10, ~a, 2'b01, a ^ 6'h2A, 2'b11,
             a + 6'd1, 2'b00};
   endfunction

   function automatic logic [11:0] amap(input int i);
      amap = 12'(((i / 8) << 8) | (((i / 2) % 4) << 4) | (i % 2));
   endfunction

   function automatic int dec(input logic [11:0] a);
      dec = int'(a[10:8]) * 8 + int'(a[5:4]) * 2 + int'(a[0]);
   endfunction

   assign tbl_data = rom(tbl_addr);

   sbox_apb_loader #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .busy(busy), .done(done), .err(err),
      .err_count(err_count), .tbl_addr(tbl_addr),
      .tbl_data(tbl_data), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   // slave model: drives PREADY/PSLVERR and logs each access phase
   always @(negedge clk) begin
      int idx;
      if (PSEL && PENABLE) begin
         k++;
         if (k == 1) begin
            cap_a = PADDR;
            cap_d = PWDATA;
         end
         if (PADDR !== cap_a || PWDATA !== cap_d || PWRITE !== 1'b1)
            unstable++;
         idx = dec(PADDR);
         PREADY = (k > wait_n) && (idx != stuck_idx);
         PSLVERR = PREADY && (idx == e0 || idx == e1);
      end else begin
         if (k > 0) begin
            log_a[n_xfer] = cap_a;
            log_d[n_xfer] = cap_d;
            log_l[n_xfer] = k;
            n_xfer++;
         end
         k = 0;
         PREADY = 1'b0;
         PSLVERR = 1'b0;
      end
      if (PSEL && !busy) viol++;
      if (PENABLE && !PSEL) viol++;
   end

   task automatic run(input int restart_at, input int budget,
                      output int n, output bit seen);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         @(posedge clk); #1;
         n++;
         start = (n == restart_at);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({PSEL, PENABLE, PWRITE, busy, done, err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 000000",
                  {PSEL, PENABLE, PWRITE, busy, done, err});
      end
      checks++;
      if (PADDR !== 12'h0 || PWDATA !== 32'h0) begin
         errors++;
         $display("FAIL reset_apb got %h/%h want 000/0", PADDR, PWDATA);
      end
      checks++;
      if (tbl_addr !== 6'd0 || err_count !== 7'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d/%0d want 0/0",
                  tbl_addr, err_count);
      end
      #2 rst = 1'b1;
   endtask

   task automatic test_full();
      int n, base, u0, v0;
      bit seen, bad;
      wait_n = 0; stuck_idx = -1; e0 = -1; e1 = -1;
      base = n_xfer; u0 = unstable; v0 = viol;
      run(50, 400, n, seen);
      checks++;
      if (!seen || n != 192) begin
         errors++;
         $display("FAIL full_latency got %0d seen %0d want 192", n, seen);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL full_busy_done got %b want 0", busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL full_done_pulse got %b want 0", done);
      end
      checks++;
      if (n_xfer - base != 64) begin
         errors++;
         $display("FAIL full_count got %0d want 64", n_xfer - base);
      end
      checks++;
      if (log_a[base] !== 12'h000 || log_d[base] !== rom(6'd0)) begin
         errors++;
         $display("FAIL full_first got %h/%h want 000/%h",
                  log_a[base], log_d[base], rom(6'd0));
      end
      checks++;
      if (log_a[base + 63] !== 12'h731 ||
          log_d[base + 63] !== rom(6'd63)) begin
         errors++;
         $display("FAIL full_last got %h/%h want 731/%h",
                  log_a[base + 63], log_d[base + 63], rom(6'd63));
      end
      bad = 1'b0;
      for (int i = 0; i < 64; i++)
         if (log_a[base + i] !== amap(i) ||
             log_d[base + i] !== rom(6'(i)) ||
             log_l[base + i] != 1) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL full_seq got mismatching entries want map/rom");
      end
      checks++;
      if (err !== 1'b0 || err_count !== 7'd0) begin
         errors++;
         $display("FAIL full_err got %b/%0d want 0/0", err, err_count);
      end
      checks++;
      if (viol != v0 || unstable != u0) begin
         errors++;
         $display("FAIL full_protocol got %0d/%0d want 0/0",
                  viol - v0, unstable - u0);
      end
   endtask

   task automatic test_wait();
      int n, base, u0;
      bit seen, bad;
      wait_n = 3; stuck_idx = -1; e0 = -1; e1 = -1;
      base = n_xfer; u0 = unstable;
      run(-1, 800, n, seen);
      @(posedge clk); #1;
      checks++;
      if (!seen || n != 384) begin
         errors++;
         $display("FAIL wait_latency got %0d seen %0d want 384", n, seen);
      end
      bad = 1'b0;
      for (int i = 0; i < 64; i++)
         if (log_l[base + i] != 4 || log_a[base + i] !== amap(i))
            bad = 1'b1;
      checks++;
      if (bad || n_xfer - base != 64) begin
         errors++;
         $display("FAIL wait_len got count %0d want 64 len 4",
                  n_xfer - base);
      end
      checks++;
      if (unstable != u0) begin
         errors++;
         $display("FAIL wait_stable got %0d want 0", unstable - u0);
      end
   endtask

   task automatic test_slverr();
      int n, base;
      bit seen;
      wait_n = 0; stuck_idx = -1; e0 = 5; e1 = 40;
      base = n_xfer;
      run(-1, 400, n, seen);
      @(posedge clk); #1;
      checks++;
      if (!seen || err !== 1'b1 || err_count !== 7'd2) begin
         errors++;
         $display("FAIL slverr_err got %b/%0d seen %0d want 1/2",
                  err, err_count, seen);
      end
      checks++;
      if (n_xfer - base != 64 || n != 192) begin
         errors++;
         $display("FAIL slverr_count got %0d/%0d want 64/192",
                  n_xfer - base, n);
      end
      e0 = -1; e1 = -1;
   endtask

   task automatic test_timeout();
      int n, base;
      bit seen;
      wait_n = 0; stuck_idx = 10; e0 = -1; e1 = -1;
      base = n_xfer;
      run(-1, 400, n, seen);
      @(posedge clk); #1;
      checks++;
      if (log_l[base + 10] != 16) begin
         errors++;
         $display("FAIL tmo_len got %0d want 16", log_l[base + 10]);
      end
      checks++;
      if (log_a[base + 11] !== amap(11) || n_xfer - base != 64) begin
         errors++;
         $display("FAIL tmo_next got %h/%0d want %h/64",
                  log_a[base + 11], n_xfer - base, amap(11));
      end
      checks++;
      if (!seen || n != 207 || err !== 1'b1 || err_count !== 7'd1) begin
         errors++;
         $display("FAIL tmo_err got n %0d err %b cnt %0d want 207/1/1",
                  n, err, err_count);
      end
      stuck_idx = -1;
   endtask

   task automatic test_abort();
      int n, base;
      bit found, seen;
      wait_n = 2; stuck_idx = -1; e0 = -1; e1 = -1;
      base = n_xfer;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (PSEL && PENABLE && PADDR == amap(7)) found = 1'b1;
      end
      abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 20) begin
         if (done) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      @(posedge clk); #1;
      checks++;
      if (!found || !seen) begin
         errors++;
         $display("FAIL abort_done got found %0d done %0d want 1/1",
                  found, seen);
      end
      checks++;
      if (n_xfer - base != 8 || log_a[n_xfer - 1] !== amap(7) ||
          log_l[n_xfer - 1] != 3) begin
         errors++;
         $display("FAIL abort_xfers got %0d last %h len %0d want 8/031/3",
                  n_xfer - base, log_a[n_xfer - 1], log_l[n_xfer - 1]);
      end
      checks++;
      if (err !== 1'b1 || err_count !== 7'd0) begin
         errors++;
         $display("FAIL abort_err got %b/%0d want 1/0", err, err_count);
      end
   endtask

   task automatic test_reset_mid();
      int n, base;
      bit found, seen;
      wait_n = 0; stuck_idx = -1; e0 = -1; e1 = -1;
      base = n_xfer;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (PSEL && !PENABLE && PADDR == amap(20)) found = 1'b1;
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if (!found || PSEL !== 1'b0 || PENABLE !== 1'b0 ||
          PWRITE !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_apb got found %0d psel %b pen %b want 1/0/0",
                  found, PSEL, PENABLE);
      end
      checks++;
      if (PADDR !== 12'h0 || PWDATA !== 32'h0 || tbl_addr !== 6'd0 ||
          {busy, done, err} !== 3'b0 || err_count !== 7'd0) begin
         errors++;
         $display("FAIL rstmid_out got %h/%h/%0d/%b/%0d want zeros",
                  PADDR, PWDATA, tbl_addr, {busy, done, err}, err_count);
      end
      #2 rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (n_xfer - base != 20 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_idle got %0d/%b want 20/0",
                  n_xfer - base, busy);
      end
      base = n_xfer;
      run(-1, 400, n, seen);
      @(posedge clk); #1;
      checks++;
      if (!seen || n != 192 || n_xfer - base != 64 ||
          log_a[base] !== 12'h000 || log_d[base] !== rom(6'd0)) begin
         errors++;
         $display("FAIL rstmid_restart got n %0d cnt %0d first %h",
                  n, n_xfer - base, log_a[base]);
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_wait();
      test_slverr();
      test_timeout();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
